// File: rtl/decode_stage.sv
// Decode stage: register read with WB write-through, immediate and control
// decode, load-use stall, flush/halt handling, registered into ID/EX.
module decode_stage #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] nextPc,
    input  logic              instrValid,
    input  logic              flush,
    input  logic              wbEn,
    input  logic [2:0]        wbReg,
    input  logic [DATA_W-1:0] wbData,
    output logic              stall,
    output logic              exValid,
    output logic [DATA_W-1:0] exPcPlus2,
    output logic [DATA_W-1:0] exRsData,
    output logic [DATA_W-1:0] exRtData,
    output logic [DATA_W-1:0] exImm,
    output logic [4:0]        exOpcode,
    output logic [1:0]        exFunct,
    output logic [2:0]        exDest,
    output logic              exRegWrite,
    output logic              exMemRead,
    output logic              exMemWrite,
    output logic              exHalt
);

    logic [DATA_W-1:0] rf [NREG];
    logic [4:0]        op;
    logic [2:0]        rsIdx;
    logic [2:0]        rtIdx;
    logic [DATA_W-1:0] rsData;
    logic [DATA_W-1:0] rtData;
    logic [DATA_W-1:0] imm;
    logic [2:0]        dest;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              usesRt;
    logic              halted;
    logic              hazard;
    logic              bubble;

    assign op    = instr[15:11];
    assign rsIdx = instr[10:8];
    assign rtIdx = instr[7:5];

    // Same-cycle writeback is visible to the read
    assign rsData = (wbEn && wbReg == rsIdx) ? wbData : rf[rsIdx];
    assign rtData = (wbEn && wbReg == rtIdx) ? wbData : rf[rtIdx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wbEn) begin
            rf[wbReg] <= wbData;
        end
    end

    always_comb begin
        regWrite = 1'b1;
        casez (op)
            5'b00000, 5'b00001, 5'b00010, 5'b00011,
            5'b00100, 5'b00101, 5'b011??, 5'b10000: regWrite = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        dest = rtIdx;
        casez (op)
            5'b11010, 5'b11011, 5'b111??: dest = instr[4:2];
            5'b11000, 5'b10010:           dest = rsIdx;
            5'b00110, 5'b00111:           dest = 3'd7;
            default: ;
        endcase
    end

    always_comb begin
        imm = {{(DATA_W-5){instr[4]}}, instr[4:0]};
        casez (op)
            5'b00100, 5'b00110:
                imm = {{(DATA_W-11){instr[10]}}, instr[10:0]};
            5'b011??, 5'b11000, 5'b00101, 5'b00111:
                imm = {{(DATA_W-8){instr[7]}}, instr[7:0]};
            5'b10010:
                imm = {{(DATA_W-8){1'b0}}, instr[7:0]};
            5'b0101?:
                imm = {{(DATA_W-5){1'b0}}, instr[4:0]};
            default: ;
        endcase
    end

    always_comb begin
        usesRt = 1'b0;
        casez (op)
            5'b11010, 5'b11011, 5'b111??,
            5'b10000, 5'b10011: usesRt = 1'b1;
            default: ;
        endcase
    end

    assign memRead  = (op == 5'b10001);
    assign memWrite = (op == 5'b10000) || (op == 5'b10011);

    assign hazard = exValid && exMemRead && exRegWrite &&
                    (exDest == rsIdx || (usesRt && exDest == rtIdx));
    assign stall  = instrValid && hazard && !flush && !halted && !rst;
    assign bubble = flush || halted || stall || !instrValid;
    assign exHalt = halted;

    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (!bubble && op == 5'b00000) begin
            halted <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            exValid    <= 1'b0;
            exPcPlus2  <= '0;
            exRsData   <= '0;
            exRtData   <= '0;
            exImm      <= '0;
            exOpcode   <= '0;
            exFunct    <= '0;
            exDest     <= '0;
            exRegWrite <= 1'b0;
            exMemRead  <= 1'b0;
            exMemWrite <= 1'b0;
        end else begin
            exValid    <= 1'b1;
            exPcPlus2  <= nextPc;
            exRsData   <= rsData;
            exRtData   <= rtData;
            exImm      <= imm;
            exOpcode   <= op;
            exFunct    <= instr[1:0];
            exDest     <= dest;
            exRegWrite <= regWrite;
            exMemRead  <= memRead;
            exMemWrite <= memWrite;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: opcode-table model checked every cycle plus
// directed vectors with literal expectations.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic [15:0] nextPc;
    logic        instrValid;
    logic        flush;
    logic        wbEn;
    logic [2:0]  wbReg;
    logic [15:0] wbData;
    logic        stall;
    logic        exValid;
    logic [15:0] exPcPlus2;
    logic [15:0] exRsData;
    logic [15:0] exRtData;
    logic [15:0] exImm;
    logic [4:0]  exOpcode;
    logic [1:0]  exFunct;
    logic [2:0]  exDest;
    logic        exRegWrite;
    logic        exMemRead;
    logic        exMemWrite;
    logic        exHalt;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .instr(instr), .nextPc(nextPc),
        .instrValid(instrValid), .flush(flush), .wbEn(wbEn),
        .wbReg(wbReg), .wbData(wbData), .stall(stall),
        .exValid(exValid), .exPcPlus2(exPcPlus2),
        .exRsData(exRsData), .exRtData(exRtData), .exImm(exImm),
        .exOpcode(exOpcode), .exFunct(exFunct), .exDest(exDest),
        .exRegWrite(exRegWrite), .exMemRead(exMemRead),
        .exMemWrite(exMemWrite), .exHalt(exHalt)
    );

    int nChk = 0;
    int nPass = 0;
    bit go = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nChk++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    // Expected-value model, expressed as opcode set membership
    logic [15:0] mRegs [8];
    logic        mValid, mRw, mMr, mMw, mHalted;
    logic [15:0] mPc, mRs, mRt, mImm;
    logic [4:0]  mOp;
    logic [1:0]  mFunct;
    logic [2:0]  mDest;

    function automatic bit noWrite(logic [4:0] op);
        return (op <= 5'd5) || (op[4:2] == 3'b011) || (op == 5'd16);
    endfunction

    function automatic logic [2:0] expDest(logic [15:0] i);
        logic [4:0] op = i[15:11];
        if (op == 5'd26 || op == 5'd27 || op >= 5'd28) return i[4:2];
        if (op == 5'd24 || op == 5'd18) return i[10:8];
        if (op == 5'd6 || op == 5'd7) return 3'd7;
        return i[7:5];
    endfunction

    function automatic logic [15:0] expImm(logic [15:0] i);
        logic [4:0] op = i[15:11];
        if (op == 5'd4 || op == 5'd6) return 16'($signed(i[10:0]));
        if (op[4:2] == 3'b011 || op == 5'd24 || op == 5'd5 || op == 5'd7)
            return 16'($signed(i[7:0]));
        if (op == 5'd18) return {8'h00, i[7:0]};
        if (op == 5'd10 || op == 5'd11) return {11'd0, i[4:0]};
        return 16'($signed(i[4:0]));
    endfunction

    function automatic bit expUsesRt(logic [4:0] op);
        return op == 5'd26 || op == 5'd27 || op >= 5'd28 ||
               op == 5'd16 || op == 5'd19;
    endfunction

    function automatic logic [15:0] rd(logic [2:0] r);
        return (wbEn && wbReg == r) ? wbData : mRegs[r];
    endfunction

    function automatic bit expStall();
        bit dep;
        dep = (mDest == instr[10:8]) ||
              (expUsesRt(instr[15:11]) && mDest == instr[7:5]);
        return !rst && instrValid && mValid && mMr && mRw && dep &&
               !flush && !mHalted;
    endfunction

    always @(posedge clk) begin
        bit s;
        if (rst) begin
            for (int i = 0; i < 8; i++) mRegs[i] = 16'h0;
            mValid = 0; mRw = 0; mMr = 0; mMw = 0; mHalted = 0;
        end else begin
            s = expStall();
            if (flush || mHalted || s || !instrValid) begin
                mValid = 0; mRw = 0; mMr = 0; mMw = 0;
            end else begin
                mValid = 1;
                mPc    = nextPc;
                mRs    = rd(instr[10:8]);
                mRt    = rd(instr[7:5]);
                mImm   = expImm(instr);
                mOp    = instr[15:11];
                mFunct = instr[1:0];
                mDest  = expDest(instr);
                mRw    = !noWrite(instr[15:11]);
                mMr    = instr[15:11] == 5'd17;
                mMw    = instr[15:11] == 5'd16 || instr[15:11] == 5'd19;
                if (instr[15:11] == 5'd0) mHalted = 1;
            end
            if (wbEn) mRegs[wbReg] = wbData;
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("stall", stall, expStall());
            chk("exValid", exValid, mValid);
            chk("exHalt", exHalt, mHalted);
            chk("exRegWrite", exRegWrite, mRw);
            chk("exMemRead", exMemRead, mMr);
            chk("exMemWrite", exMemWrite, mMw);
            if (mValid) begin
                chk("exPcPlus2", exPcPlus2, mPc);
                chk("exRsData", exRsData, mRs);
                chk("exRtData", exRtData, mRt);
                chk("exImm", exImm, mImm);
                chk("exOpcode", exOpcode, mOp);
                chk("exFunct", exFunct, mFunct);
                chk("exDest", exDest, mDest);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(logic [15:0] i, logic [15:0] pc);
        instr = i; nextPc = pc; instrValid = 1'b1;
    endtask

    typedef struct {
        logic [15:0] i;
        logic [15:0] imm;
        logic [2:0]  dest;
        logic        rw;
    } vec_t;

    vec_t vecs [7] = '{
        '{16'h93F0, 16'h00F0, 3'd3, 1'b1},
        '{16'h501F, 16'h001F, 3'd0, 1'b1},
        '{16'h6080, 16'hFF80, 3'd4, 1'b0},
        '{16'hC4FF, 16'hFFFF, 3'd4, 1'b1},
        '{16'h2C05, 16'h0005, 3'd0, 1'b0},
        '{16'h9A40, 16'h0000, 3'd2, 1'b1},
        '{16'h2400, 16'hFC00, 3'd0, 1'b0}
    };

    initial begin
        rst = 1; instr = 0; nextPc = 0; instrValid = 0; flush = 0;
        wbEn = 0; wbReg = 0; wbData = 0;
        tick();
        go = 1'b1;
        tick();
        chk("rst exValid", exValid, 0);
        chk("rst exHalt", exHalt, 0);
        chk("rst stall", stall, 0);

        rst = 0;
        tick();
        tick();
        chk("idle exValid", exValid, 0);
        chk("idle exHalt", exHalt, 0);

        wbEn = 1; wbReg = 3; wbData = 16'hBEEF;
        tick();
        wbEn = 0;
        dec(16'h4B3F, 16'h0002);
        tick();
        chk("addi rs", exRsData, 16'hBEEF);
        chk("addi imm", exImm, 16'hFFFF);
        chk("addi dest", exDest, 1);
        chk("addi rw", exRegWrite, 1);

        dec(16'hDAB0, 16'h0004);
        wbEn = 1; wbReg = 2; wbData = 16'h1234;
        tick();
        wbEn = 0;
        chk("wt rs", exRsData, 16'h1234);
        chk("wt dest", exDest, 4);

        dec(16'h8A20, 16'h0006);
        tick();
        chk("ld memRead", exMemRead, 1);
        dec(16'hD964, 16'h0008);
        #1 chk("lu stall", stall, 1);
        tick();
        chk("lu bubble", exValid, 0);
        chk("lu stall clr", stall, 0);
        tick();
        chk("lu issue", exValid, 1);
        chk("lu issue dest", exDest, 1);

        dec(16'h8A20, 16'h000A);
        tick();
        dec(16'hD964, 16'h000C);
        flush = 1;
        #1 chk("fl stall", stall, 0);
        tick();
        flush = 0;
        chk("fl bubble", exValid, 0);
        tick();
        chk("fl reissue", exValid, 1);

        foreach (vecs[k]) begin
            dec(vecs[k].i, 16'h0020 + 16'(k));
            tick();
            chk("vec imm", exImm, vecs[k].imm);
            chk("vec dest", exDest, vecs[k].dest);
            chk("vec rw", exRegWrite, vecs[k].rw);
        end

        dec(16'h3008, 16'h0010);
        tick();
        chk("jal dest", exDest, 7);
        chk("jal imm", exImm, 16'h0008);
        chk("jal pc", exPcPlus2, 16'h0010);
        chk("jal rw", exRegWrite, 1);

        instrValid = 0;
        wbEn = 1; wbReg = 6; wbData = 16'h5A5A;
        tick();
        wbEn = 0;
        dec(16'hDE00, 16'h0012);
        tick();
        chk("rf hold", exRsData, 16'h5A5A);

        dec(16'h0000, 16'h0014);
        flush = 1;
        tick();
        flush = 0;
        chk("fl halt", exHalt, 0);
        chk("fl halt v", exValid, 0);

        dec(16'h0000, 16'h0016);
        tick();
        chk("halt", exHalt, 1);
        chk("halt v", exValid, 1);
        dec(16'hDAB0, 16'h0018);
        tick();
        chk("post halt v", exValid, 0);
        chk("post halt h", exHalt, 1);

        rst = 1;
        wbEn = 1; wbReg = 4; wbData = 16'hAAAA;
        tick();
        rst = 0; wbEn = 0;
        chk("rst halt", exHalt, 0);
        chk("rst v", exValid, 0);
        dec(16'hDC00, 16'h001A);
        tick();
        chk("rst wb drop", exRsData, 16'h0000);

        instrValid = 0;
        tick();
        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
